led7_scan_ctrl: RTL

- Time-multiplexed scan controller for a bank of common-anode/common-cathode 7-segment digits that share a single led7_decoder.
- Each cycle it drives the decoder's 4-bit `in` and `on` inputs, plus one-hot digit enables, rotating through the digits at a programmable refresh rate.
- A guard (all-off) interval between digits suppresses ghosting.
- Display data is double-buffered and swapped only at frame boundaries, so a frame never tears.

---
 rtl/led7_scan_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/led7_scan_ctrl.sv
// Time-multiplexed scan controller for a bank of 7-segment digits that share one led7_decoder.
// Rotates SHOW/GUARD per digit and swaps double-buffered display data only at frame start.
module led7_scan_ctrl #(
    parameter int unsigned NUM_DIGITS       = 4,
    parameter int unsigned REFRESH_DIV      = 50000,
    parameter int unsigned GUARD_CYCLES     = 2500,
    parameter int unsigned ANODE_ACTIVE_LOW = 1,
    parameter int unsigned LZB              = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    output logic [3:0]              dec_in,
    output logic                    dec_on,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int unsigned DW         = 4 * NUM_DIGITS;
    localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_MAX    = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int unsigned CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
    localparam int unsigned SHOW_LAST  = (REFRESH_DIV > 0) ? REFRESH_DIV - 1 : 0;
    localparam int unsigned GUARD_LAST = (GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0;

    localparam logic [NUM_DIGITS-1:0] AN_OFF   = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_GUARD = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DW-1:0]           shadow_q, shadow_d;
    logic [DW-1:0]           pending_q, pending_d;
    logic                    pending_valid_q, pending_valid_d;
    logic [3:0]              dec_in_q, dec_in_d;
    logic                    dec_on_q, dec_on_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_done_q, frame_done_d;
    logic                    frame_start;
    logic [IDX_W-1:0]        idx_next;
    logic [NUM_DIGITS-1:0]   onehot;
    logic [NUM_DIGITS-1:0]   blank;

    // Digit k is blanked when it and every more significant nibble are zero; digit 0 never is.
    function automatic logic [NUM_DIGITS-1:0] lzb_mask(input logic [DW-1:0] s);
        logic                  run;
        logic [NUM_DIGITS-1:0] mask;
        run  = 1'b1;
        mask = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            run     = run & (s[4*k +: 4] == 4'd0);
            mask[k] = run;
        end
        return mask;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            idx_q           <= '0;
            cnt_q           <= '0;
            shadow_q        <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            dec_in_q        <= 4'd0;
            dec_on_q        <= 1'b0;
            an_q            <= AN_OFF;
            frame_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            cnt_q           <= cnt_d;
            shadow_q        <= shadow_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            dec_in_q        <= dec_in_d;
            dec_on_q        <= dec_on_d;
            an_q            <= an_d;
            frame_done_q    <= frame_done_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        cnt_d           = cnt_q + CNT_W'(1);
        shadow_d        = shadow_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        dec_in_d        = dec_in_q;
        dec_on_d        = 1'b0;
        an_d            = AN_OFF;
        frame_done_d    = 1'b0;
        frame_start     = 1'b0;
        onehot          = '0;
        blank           = '0;
        idx_next        = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

        // Sequencing; cnt restarts on every state change.
        unique case (state_q)
            ST_IDLE: begin
                state_d     = ST_SHOW;
                idx_d       = '0;
                cnt_d       = '0;
                frame_start = 1'b1;
            end
            ST_SHOW: begin
                if (cnt_q == CNT_W'(SHOW_LAST)) begin
                    cnt_d = '0;
                    if (GUARD_CYCLES == 0) begin
                        idx_d       = idx_next;
                        frame_start = (idx_q == IDX_LAST);
                    end else begin
                        state_d = ST_GUARD;
                    end
                end
            end
            ST_GUARD: begin
                if (cnt_q == CNT_W'(GUARD_LAST)) begin
                    state_d     = ST_SHOW;
                    cnt_d       = '0;
                    idx_d       = idx_next;
                    frame_start = (idx_q == IDX_LAST);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase

        // Double buffer: a load coinciding with frame start bypasses pending.
        if (frame_start) begin
            pending_valid_d = 1'b0;
            if (load) begin
                shadow_d = digits_in;
            end else if (pending_valid_q) begin
                shadow_d = pending_q;
            end
        end else if (load) begin
            pending_d       = digits_in;
            pending_valid_d = 1'b1;
        end

        // Outputs are computed from next-state values so they align with the registered state.
        if (LZB != 0) begin
            blank = lzb_mask(shadow_d);
        end
        if (state_d == ST_SHOW) begin
            onehot       = NUM_DIGITS'(1) << idx_d;
            an_d         = AN_OFF ^ onehot;
            dec_in_d     = shadow_d[{idx_d, 2'b00} +: 4];
            dec_on_d     = digit_en[idx_d] & ~blank[idx_d];
            frame_done_d = frame_start;
        end
    end

    assign dec_in     = dec_in_q;
    assign dec_on     = dec_on_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule
